// File: rtl/dmem_arbiter_pkg.sv
// ============================================================================
// Package : definitions
// Brief   : Shared memory bundle types and arbiter state encoding.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package definitions;

  // Request bundle from a core (or from the arbiter to the memory).
  typedef struct packed {
    logic [31:0] write_data;
    logic        valid;
    logic        wen;
    logic        byte_not_word;
    logic        yumi;
  } mem_in_s;

  // Response bundle from the memory (or from the arbiter to a core).
  typedef struct packed {
    logic [31:0] read_data;
    logic        valid;
    logic        yumi;
  } mem_out_s;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } dmem_arb_state_e;

  // Width of a core index; never zero so single-core builds still elaborate.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_arbiter_rr.sv
// ============================================================================
// Module : rr_arbiter
// Brief  : Combinational round-robin pick, searching from last_owner+1.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
  import definitions::*;
#(
  parameter int NUM_CORES = 4,
  parameter int IDX_W     = idx_width(NUM_CORES)
) (
  input  logic [NUM_CORES-1:0] i_req,
  input  logic [IDX_W-1:0]     i_last_owner,
  output logic [NUM_CORES-1:0] o_grant,
  output logic [IDX_W-1:0]     o_idx
);

  logic             w_found;
  logic [IDX_W-1:0] w_k;

  // Walk the cores starting just after the previous owner; first requester wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_k     = '0;
    for (int i = 1; i <= NUM_CORES; i++) begin
      w_k = IDX_W'((int'(i_last_owner) + i) % NUM_CORES);
      if (!w_found && i_req[w_k]) begin
        o_grant[w_k] = 1'b1;
        o_idx        = w_k;
        w_found      = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module : dmem_arbiter
// Brief  : Shares one data memory between several cores, one transaction at
//          a time, with round-robin ownership and a sticky timeout flag.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arbiter
  import definitions::*;
#(
  parameter int num_cores_p = 4,
  parameter int timeout_p   = 255
) (
  input  logic                         clk,
  input  logic                         n_reset,
  input  mem_in_s  [num_cores_p-1:0]   core_req_i,
  input  logic [num_cores_p-1:0][31:0] core_addr_i,
  output mem_out_s [num_cores_p-1:0]   core_resp_o,
  output mem_in_s                      mem_o,
  output logic [31:0]                  mem_addr_o,
  input  mem_out_s                     mem_i,
  output logic [num_cores_p-1:0]       grant_o,
  output logic                         error_o
);

  localparam int IDX_W = idx_width(num_cores_p);
  localparam int TMR_W = $clog2(timeout_p + 1);

  dmem_arb_state_e        r_state, w_state_next;
  logic [IDX_W-1:0]       r_owner, r_last_owner;
  logic [TMR_W-1:0]       r_timer, w_timer_inc;
  logic                   r_error;
  logic                   w_timeout, w_complete;
  logic [num_cores_p-1:0] w_req_valid, w_arb_grant;
  logic [IDX_W-1:0]       w_arb_idx;
  mem_in_s                w_owner_req;

  assign w_owner_req = core_req_i[r_owner];
  assign w_timer_inc = r_timer + TMR_W'(1);
  assign error_o     = r_error;

  // Gather the per-core valid bits for the arbiter.
  always_comb begin
    w_req_valid = '0;
    for (int k = 0; k < num_cores_p; k++) begin
      w_req_valid[k] = core_req_i[k].valid;
    end
  end

  rr_arbiter #(
    .NUM_CORES (num_cores_p),
    .IDX_W     (IDX_W)
  ) u_rr (
    .i_req        (w_req_valid),
    .i_last_owner (r_last_owner),
    .o_grant      (w_arb_grant),
    .o_idx        (w_arb_idx)
  );

  // Next state and all routing; only the owner's response is ever non-zero.
  always_comb begin
    w_state_next = r_state;
    w_timeout    = 1'b0;
    w_complete   = 1'b0;
    mem_o        = '0;
    mem_addr_o   = '0;
    core_resp_o  = '0;
    grant_o      = '0;
    case (r_state)
      IDLE: begin
        if (|w_arb_grant) w_state_next = REQ;
      end
      REQ, WAIT: begin
        grant_o[r_owner]    = 1'b1;
        mem_o.write_data    = w_owner_req.write_data;
        mem_o.valid         = w_owner_req.valid;
        mem_o.wen           = w_owner_req.wen;
        mem_o.byte_not_word = w_owner_req.byte_not_word;
        mem_addr_o          = core_addr_i[r_owner];
        // Timeout wins over everything and suppresses any ack to the owner.
        if (w_timer_inc == TMR_W'(timeout_p)) begin
          w_timeout    = 1'b1;
          w_state_next = IDLE;
        end else if (r_state == REQ) begin
          if (!w_owner_req.valid) begin
            w_state_next = IDLE;
          end else if (mem_i.yumi) begin
            core_resp_o[r_owner].yumi = 1'b1;
            w_state_next              = WAIT;
            if (mem_i.valid) begin
              core_resp_o[r_owner].valid     = 1'b1;
              core_resp_o[r_owner].read_data = mem_i.read_data;
              mem_o.yumi                     = w_owner_req.yumi;
              if (w_owner_req.yumi) begin
                w_complete   = 1'b1;
                w_state_next = IDLE;
              end
            end
          end
        end else begin
          core_resp_o[r_owner].valid     = mem_i.valid;
          core_resp_o[r_owner].read_data = mem_i.read_data;
          mem_o.yumi                     = w_owner_req.yumi;
          if (mem_i.valid && w_owner_req.yumi) begin
            w_complete   = 1'b1;
            w_state_next = IDLE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State, owner bookkeeping, timeout counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_state      <= IDLE;
      r_owner      <= '0;
      r_last_owner <= IDX_W'(num_cores_p - 1);
      r_timer      <= '0;
      r_error      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == IDLE) begin
        r_timer <= '0;
        if (|w_arb_grant) r_owner <= w_arb_idx;
      end else begin
        r_timer <= w_timer_inc;
      end
      if (w_complete) r_last_owner <= r_owner;
      if (w_timeout)  r_error      <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// Module : tb_dmem_arbiter
// Brief  : Directed self-checking bench for dmem_arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;
  import definitions::*;

  logic                clk;
  logic                n_reset;
  mem_in_s  [3:0]      core_req;
  logic [3:0][31:0]    core_addr;
  mem_out_s [3:0]      core_resp;
  mem_in_s             mem_req;
  logic [31:0]         mem_addr;
  mem_out_s            mem_rsp;
  logic [3:0]          grant;
  logic                error;

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.num_cores_p(4), .timeout_p(255)) dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .core_req_i  (core_req),
    .core_addr_i (core_addr),
    .core_resp_o (core_resp),
    .mem_o       (mem_req),
    .mem_addr_o  (mem_addr),
    .mem_i       (mem_rsp),
    .grant_o     (grant),
    .error_o     (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_core(input int k, input logic v, input logic wen, input logic y,
                          input logic [31:0] a, input logic [31:0] d);
    core_req[k].valid         = v;
    core_req[k].wen           = wen;
    core_req[k].yumi          = y;
    core_req[k].byte_not_word = 1'b0;
    core_req[k].write_data    = d;
    core_addr[k]              = a;
  endtask

  task automatic set_mem(input logic y, input logic v, input logic [31:0] rd);
    mem_rsp.yumi      = y;
    mem_rsp.valid     = v;
    mem_rsp.read_data = rd;
  endtask

  task automatic clear_cores;
    core_req  = '0;
    core_addr = '0;
  endtask

  int order[5] = '{0, 1, 2, 3, 0};

  initial begin
    n_reset = 1'b0;
    clear_cores();
    mem_rsp = '0;

    // Reset state
    tick(); tick();
    n_reset = 1'b1;
    #1;
    chk("rst_grant", 64'(grant), 64'h0);
    chk("rst_error", 64'(error), 64'h0);
    chk("rst_memvalid", 64'(mem_req.valid), 64'h0);
    chk("rst_resp0", 64'(core_resp[0]), 64'h0);

    // Single write by core 2
    set_core(2, 1'b1, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF);
    #1;
    chk("w2_idle_grant", 64'(grant), 64'h0);
    chk("w2_idle_memvalid", 64'(mem_req.valid), 64'h0);
    tick(); #1;
    chk("w2_grant", 64'(grant), 64'h4);
    chk("w2_addr", 64'(mem_addr), 64'h40);
    chk("w2_wdata", 64'(mem_req.write_data), 64'hDEADBEEF);
    chk("w2_memvalid", 64'(mem_req.valid), 64'h1);
    chk("w2_wen", 64'(mem_req.wen), 64'h1);
    chk("w2_noyumi", 64'(core_resp[2]), 64'h0);
    tick(); set_mem(1'b1, 1'b0, 32'h0); #1;
    chk("w2_yumi", 64'(core_resp[2].yumi), 64'h1);
    chk("w2_nonowner", 64'(core_resp[0]), 64'h0);
    tick(); set_mem(1'b0, 1'b0, 32'h0); core_req[2].valid = 1'b0; #1;
    chk("w2_wait_grant", 64'(grant), 64'h4);
    chk("w2_wait_novalid", 64'(core_resp[2].valid), 64'h0);
    tick(); set_mem(1'b0, 1'b1, 32'h0); #1;
    chk("w2_rvalid", 64'(core_resp[2].valid), 64'h1);
    chk("w2_memyumi", 64'(mem_req.yumi), 64'h1);
    tick(); set_mem(1'b0, 1'b0, 32'h0); #1;
    chk("w2_done_grant", 64'(grant), 64'h0);
    chk("w2_done_resp", 64'(core_resp[2]), 64'h0);

    // Owner drops valid in REQ: abandon without ack, last owner kept
    clear_cores();
    set_core(3, 1'b1, 1'b0, 1'b1, 32'h44, 32'h0);
    tick(); #1;
    chk("drop_grant", 64'(grant), 64'h8);
    core_req[3].valid = 1'b0;
    tick(); #1;
    chk("drop_idle", 64'(grant), 64'h0);
    chk("drop_noack", 64'(core_resp[3]), 64'h0);
    set_core(3, 1'b1, 1'b0, 1'b1, 32'h44, 32'h0);
    set_core(0, 1'b1, 1'b0, 1'b1, 32'h48, 32'h0);
    set_mem(1'b1, 1'b1, 32'hA5);
    tick(); #1;
    chk("drop_last_kept", 64'(grant), 64'h8);
    chk("same_cycle_resp", 64'(core_resp[3]), {30'h0, 32'hA5, 2'b11});
    chk("same_cycle_memyumi", 64'(mem_req.yumi), 64'h1);
    tick(); clear_cores(); set_mem(1'b0, 1'b0, 32'h0); #1;
    chk("same_cycle_idle", 64'(grant), 64'h0);

    // All four cores requesting from reset: strict rotation
    n_reset = 1'b0;
    tick(); tick();
    n_reset = 1'b1;
    for (int k = 0; k < 4; k++) set_core(k, 1'b1, 1'b0, 1'b1, 32'(k * 4), 32'h0);
    set_mem(1'b1, 1'b1, 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick(); #1;
      chk($sformatf("rr_grant%0d", i), 64'(grant), 64'(4'b0001 << order[i]));
      tick(); #1;
      chk($sformatf("rr_idle%0d", i), 64'(grant), 64'h0);
    end
    clear_cores(); set_mem(1'b0, 1'b0, 32'h0);

    // Load by core 1 with the core delaying its yumi
    set_core(1, 1'b1, 1'b0, 1'b0, 32'h80, 32'h0);
    tick(); #1;
    chk("ld_grant", 64'(grant), 64'h2);
    chk("ld_wen", 64'(mem_req.wen), 64'h0);
    chk("ld_addr", 64'(mem_addr), 64'h80);
    set_mem(1'b1, 1'b0, 32'h0); #1;
    chk("ld_yumi", 64'(core_resp[1].yumi), 64'h1);
    tick(); set_mem(1'b0, 1'b1, 32'h12345678); #1;
    chk("ld_rvalid", 64'(core_resp[1].valid), 64'h1);
    chk("ld_rdata", 64'(core_resp[1].read_data), 64'h12345678);
    chk("ld_memyumi0", 64'(mem_req.yumi), 64'h0);
    tick(); #1;
    chk("ld_hold_grant", 64'(grant), 64'h2);
    chk("ld_hold_memyumi", 64'(mem_req.yumi), 64'h0);
    tick(); core_req[1].yumi = 1'b1; core_req[1].valid = 1'b0; #1;
    chk("ld_memyumi1", 64'(mem_req.yumi), 64'h1);
    tick(); clear_cores(); set_mem(1'b0, 1'b0, 32'h0); #1;
    chk("ld_done", 64'(grant), 64'h0);

    // Memory never answers: timeout after 255 cycles in REQ/WAIT
    set_core(0, 1'b1, 1'b1, 1'b1, 32'hC0, 32'h1);
    tick(); #1;
    chk("to_grant", 64'(grant), 64'h1);
    chk("to_err0", 64'(error), 64'h0);
    repeat (253) tick();
    #1;
    chk("to_c254_grant", 64'(grant), 64'h1);
    chk("to_c254_err", 64'(error), 64'h0);
    tick(); #1;
    chk("to_c255_grant", 64'(grant), 64'h1);
    tick();
    clear_cores();
    set_core(2, 1'b1, 1'b0, 1'b1, 32'hC4, 32'h0);
    set_mem(1'b1, 1'b1, 32'h0);
    #1;
    chk("to_err1", 64'(error), 64'h1);
    chk("to_idle_grant", 64'(grant), 64'h0);
    tick(); #1;
    chk("to_next_grant", 64'(grant), 64'h4);
    chk("to_sticky", 64'(error), 64'h1);
    tick(); clear_cores(); set_mem(1'b0, 1'b0, 32'h0); #1;
    chk("to_next_idle", 64'(grant), 64'h0);
    chk("to_sticky2", 64'(error), 64'h1);

    // Reset during WAIT of core 3
    set_core(3, 1'b1, 1'b0, 1'b1, 32'hE0, 32'h0);
    set_mem(1'b1, 1'b0, 32'h0);
    tick(); #1;
    chk("rw_grant", 64'(grant), 64'h8);
    tick(); set_mem(1'b0, 1'b0, 32'h0); #1;
    chk("rw_wait_grant", 64'(grant), 64'h8);
    n_reset = 1'b0;
    tick();
    n_reset = 1'b1;
    set_core(0, 1'b1, 1'b0, 1'b1, 32'hE4, 32'h0);
    #1;
    chk("rw_grant0", 64'(grant), 64'h0);
    chk("rw_err0", 64'(error), 64'h0);
    chk("rw_memvalid", 64'(mem_req.valid), 64'h0);
    chk("rw_resp3", 64'(core_resp[3]), 64'h0);
    tick(); #1;
    chk("rw_core0_first", 64'(grant), 64'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
